// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and sizing helpers for the multiplexed BCD display scanner.
package bcd_display_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic logic bcd_valid(bcd_t digit);
        return digit <= BCD_MAX;
    endfunction

    function automatic int unsigned cnt_width(int unsigned refresh_div, int unsigned blank_cycles);
        int unsigned max_len;
        max_len = refresh_div;
        if (blank_cycles > max_len) begin
            max_len = blank_cycles;
        end
        if (max_len < 1) begin
            max_len = 1;
        end
        return $clog2(max_len + 1);
    endfunction

    function automatic int unsigned idx_width(int unsigned num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load/display bundle between a digit source (master) and the scanner (slave).
interface bcd_display_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import bcd_display_pkg::*;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    blank_leading;
    logic                    load_ready;
    bcd_t                    bcd_out;
    logic                    seg_en;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;

    modport master (
        output load,
        output bcd_in,
        output blank_leading,
        input  load_ready,
        input  bcd_out,
        input  seg_en,
        input  digit_sel,
        input  frame_done
    );

    modport slave (
        input  load,
        input  bcd_in,
        input  blank_leading,
        output load_ready,
        output bcd_out,
        output seg_en,
        output digit_sel,
        output frame_done
    );

endinterface

// File: rtl/bcd_display_scanner_scan_timer.sv
// Phase counter and BLANK/SHOW sequencer; walks the digit index once per slot.
module scan_timer
    import bcd_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2,
    localparam int unsigned IdxW        = idx_width(NUM_DIGITS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [IdxW-1:0] idx_o,
    output scan_state_t     state_o,
    output logic            end_of_frame_o
);

    localparam int unsigned CntW      = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam int unsigned ShowLast  = REFRESH_DIV - 1;
    localparam int unsigned BlankLast = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int unsigned LastIdx   = NUM_DIGITS - 1;

    scan_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            show_end;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        show_end = 1'b0;
        case (state_q)
            ST_BLANK: begin
                // With no blank phase this state is only seen once, right after reset.
                if (cnt_q == CntW'(BlankLast)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CntW'(ShowLast)) begin
                    show_end = 1'b1;
                    cnt_d    = '0;
                    idx_d    = (idx_q == IdxW'(LastIdx)) ? '0 : idx_q + IdxW'(1);
                    state_d  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign idx_o          = idx_q;
    assign state_o        = state_q;
    assign end_of_frame_o = show_end && (idx_q == IdxW'(LastIdx));

endmodule

// File: rtl/bcd_display_scanner.sv
// N-digit 7-segment scanner: double-buffered digit load, leading-zero and invalid-code blanking,
// one-hot digit select. Outputs decode from registered state only.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    bcd_display_scanner_if.slave  bus
);

    localparam int unsigned IdxW = idx_width(NUM_DIGITS);

    logic [IdxW-1:0] idx;
    scan_state_t     state;
    logic            end_of_frame;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .idx_o         (idx),
        .state_o       (state),
        .end_of_frame_o(end_of_frame)
    );

    bcd_t [NUM_DIGITS-1:0] bcd_in_digits;
    bcd_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    bcd_t [NUM_DIGITS-1:0] disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  blank_lead_q, blank_lead_d;

    assign bcd_in_digits = bus.bcd_in;

    // Shadow capture and frame-boundary commit; a load on the commit cycle bypasses the shadow.
    always_comb begin
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        disp_d       = disp_q;
        blank_lead_d = bus.blank_leading;
        if (bus.load) begin
            shadow_d  = bcd_in_digits;
            pending_d = 1'b1;
        end
        if (end_of_frame) begin
            if (bus.load) begin
                disp_d = bcd_in_digits;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            disp_q       <= '0;
            blank_lead_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            blank_lead_q <= blank_lead_d;
        end
    end

    // upper_zero[i] is set when digit i and every more significant digit are zero.
    logic [NUM_DIGITS-1:0] upper_zero;

    always_comb begin
        upper_zero                 = '0;
        upper_zero[NUM_DIGITS-1]   = (disp_q[NUM_DIGITS-1] == 4'd0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            upper_zero[i] = (disp_q[i] == 4'd0) && upper_zero[i+1];
        end
    end

    logic show;
    bcd_t cur_digit;
    logic lead_blank;

    always_comb begin
        show       = (state == ST_SHOW);
        cur_digit  = disp_q[idx];
        lead_blank = blank_lead_q && (idx != '0) && upper_zero[idx];

        bus.digit_sel  = '0;
        bus.bcd_out    = '0;
        bus.seg_en     = 1'b0;
        if (show) begin
            bus.digit_sel = NUM_DIGITS'(1) << idx;
            bus.bcd_out   = cur_digit;
            bus.seg_en    = bcd_valid(cur_digit) && !lead_blank;
        end
        bus.load_ready = !pending_q;
        bus.frame_done = end_of_frame;
    end

endmodule
